// File: rtl/rope_render_sched_if.sv
// rtl/rope_render_sched_if.sv - bundle of VGA, rope core and render signals around the scheduler
interface rope_render_sched_if #(
    parameter int N_NODES = 20
);
    logic [9:0]            pix_x;
    logic [9:0]            pix_y;
    logic [10*N_NODES-1:0] nodes_x;
    logic [10*N_NODES-1:0] nodes_y;
    logic                  step_done;
    logic                  step_req;
    logic [10*N_NODES-1:0] shadow_x;
    logic [10*N_NODES-1:0] shadow_y;
    logic [N_NODES-1:0]    row_mask;
    logic [15:0]           frame_cnt;
    logic                  overrun;

    // Drives timing, live node positions and step completion; observes the scheduler
    modport master (
        output pix_x, pix_y, nodes_x, nodes_y, step_done,
        input  step_req, shadow_x, shadow_y, row_mask, frame_cnt, overrun
    );

    // The scheduler itself
    modport slave (
        input  pix_x, pix_y, nodes_x, nodes_y, step_done,
        output step_req, shadow_x, shadow_y, row_mask, frame_cnt, overrun
    );
endinterface

// File: rtl/rope_render_sched.sv
// rtl/rope_render_sched.sv - per-frame physics step request, shadow snapshot and per-line row candidate scan
module rope_render_sched #(
    parameter int N_NODES  = 20,
    parameter int RADIUS   = 10,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic               clk_i,
    input  logic               reset_i,
    rope_render_sched_if.slave bus
);

    localparam int                IDX_W    = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam logic [9:0]        H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]        V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]        V_PRE    = 10'(V_ACTIVE - 1);
    localparam logic [9:0]        V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_NODES - 1);
    localparam logic [10:0]       RAD      = 11'(RADIUS);

    typedef enum logic [1:0] {F_IDLE, F_WAIT, F_COPY} frame_state_t;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PUB} scan_state_t;

    frame_state_t fstate_q, fstate_d;
    scan_state_t  sstate_q, sstate_d;

    logic [9:0]            pix_x_q, pix_y_q;
    logic                  step_req_q, step_req_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  overrun_q, overrun_d;
    logic                  shadow_load;
    logic [10*N_NODES-1:0] shadow_x_q, shadow_y_q;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [N_NODES-1:0]    work_q, work_d;
    logic [N_NODES-1:0]    row_mask_q, row_mask_d;
    logic [9:0]            next_row_q, next_row_d;

    logic                  pix_changed;
    logic                  vbs_trig;
    logic                  line_trig;
    logic                  wrap_line;
    logic                  timeout;
    logic [9:0]            next_row_in;
    logic [9:0]            sel_y;
    logic signed [10:0]    dy;
    logic [10:0]           dy_abs;
    logic                  node_hit;

    // Previous pixel position; 3FF makes the first post-reset position count as a change
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pix_x_q <= 10'h3FF;
            pix_y_q <= 10'h3FF;
        end else begin
            pix_x_q <= bus.pix_x;
            pix_y_q <= bus.pix_y;
        end
    end

    // Edge-qualified triggers: a held pixel fires once, on its first clk
    always_comb begin
        pix_changed = (bus.pix_x != pix_x_q) || (bus.pix_y != pix_y_q);
        wrap_line   = (bus.pix_y == V_LAST);
        vbs_trig    = pix_changed && (bus.pix_y == V_ACT) && (bus.pix_x == 10'd0);
        line_trig   = pix_changed && (bus.pix_x == H_ACT) && ((bus.pix_y < V_PRE) || wrap_line);
        timeout     = line_trig && wrap_line;
        next_row_in = wrap_line ? 10'd0 : bus.pix_y + 10'd1;
    end

    // Frame FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) fstate_q <= F_IDLE;
        else         fstate_q <= fstate_d;
    end

    // Frame FSM next state; step_done beats the row-0 deadline when both arrive together
    always_comb begin
        fstate_d = fstate_q;
        case (fstate_q)
            F_IDLE: if (vbs_trig) fstate_d = F_WAIT;
            F_WAIT: begin
                if (bus.step_done)  fstate_d = F_COPY;
                else if (timeout)   fstate_d = F_IDLE;
            end
            F_COPY: fstate_d = F_IDLE;
            default: fstate_d = F_IDLE;
        endcase
    end

    // Frame FSM outputs: step request, frame count, sticky overrun, snapshot strobe
    always_comb begin
        step_req_d  = step_req_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;
        shadow_load = 1'b0;
        case (fstate_q)
            F_IDLE: begin
                if (vbs_trig) begin
                    step_req_d  = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            F_WAIT: begin
                if (bus.step_done) begin
                    step_req_d = 1'b0;
                end else if (timeout) begin
                    step_req_d = 1'b0;
                    overrun_d  = 1'b1;
                end
            end
            F_COPY: shadow_load = 1'b1;
            default: ;
        endcase
    end

    // Frame-side registers, including the tear-free node snapshot
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            step_req_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
            overrun_q   <= 1'b0;
            shadow_x_q  <= '0;
            shadow_y_q  <= '0;
        end else begin
            step_req_q  <= step_req_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            if (shadow_load) begin
                shadow_x_q <= bus.nodes_x;
                shadow_y_q <= bus.nodes_y;
            end
        end
    end

    // Distance test for the node currently addressed by the scan index
    always_comb begin
        sel_y    = shadow_y_q[idx_q*10 +: 10];
        dy       = $signed({1'b0, sel_y}) - $signed({1'b0, next_row_q});
        dy_abs   = dy[10] ? 11'(-dy) : 11'(dy);
        node_hit = (dy_abs <= RAD);
    end

    // Row scan FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) sstate_q <= S_IDLE;
        else         sstate_q <= sstate_d;
    end

    // Row scan next state; a LINE trigger always (re)starts the scan
    always_comb begin
        sstate_d = sstate_q;
        if (line_trig) begin
            sstate_d = S_SCAN;
        end else begin
            case (sstate_q)
                S_SCAN: if (idx_q == IDX_LAST) sstate_d = S_PUB;
                S_PUB:  sstate_d = S_IDLE;
                default: sstate_d = S_IDLE;
            endcase
        end
    end

    // Row scan datapath: one node per cycle into the working mask, then publish
    always_comb begin
        idx_d      = idx_q;
        work_d     = work_q;
        row_mask_d = row_mask_q;
        next_row_d = next_row_q;
        if (line_trig) begin
            next_row_d = next_row_in;
            idx_d      = '0;
            work_d     = '0;
        end else begin
            case (sstate_q)
                S_SCAN: begin
                    work_d = work_q | (N_NODES'(node_hit) << idx_q);
                    idx_d  = idx_q + IDX_W'(1);
                end
                S_PUB:  row_mask_d = work_q;
                default: ;
            endcase
        end
    end

    // Row scan registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q      <= '0;
            work_q     <= '0;
            row_mask_q <= '0;
            next_row_q <= '0;
        end else begin
            idx_q      <= idx_d;
            work_q     <= work_d;
            row_mask_q <= row_mask_d;
            next_row_q <= next_row_d;
        end
    end

    assign bus.step_req  = step_req_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.overrun   = overrun_q;
    assign bus.shadow_x  = shadow_x_q;
    assign bus.shadow_y  = shadow_y_q;
    assign bus.row_mask  = row_mask_q;

endmodule
